// File: rtl/alu_pkg.sv
// Shared constants and types for the registered ALU: operation codes,
// mode values and the controller state encoding.
package alu_pkg;

    // Mode select
    localparam logic M_PASS  = 1'b0;
    localparam logic M_ARITH = 1'b1;

    // Pass-through codes (m = M_PASS)
    localparam logic [3:0] S_PASS_A0 = 4'b1100;
    localparam logic [3:0] S_PASS_A1 = 4'b0100;
    localparam logic [3:0] S_PASS_B  = 4'b1010;

    // Arithmetic/logic codes (m = M_ARITH)
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_ADC = 4'b0001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_AND = 4'b1011;
    localparam logic [3:0] S_OR  = 4'b0010;
    localparam logic [3:0] S_XOR = 4'b0011;
    localparam logic [3:0] S_NOT = 4'b0101;
    localparam logic [3:0] S_MUL = 4'b1110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the datapath control and the ALU.
interface alu_seq_if #(
    parameter int W = 8
);
    logic         start;
    logic         m;
    logic [3:0]   s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] t;
    logic         cf;
    logic         zf;
    logic         busy;
    logic         done;

    modport master (
        output start, m, s, a, b,
        input  t, cf, zf, busy, done
    );

    modport slave (
        input  start, m, s, a, b,
        output t, cf, zf, busy, done
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per clock.
// The product register holds {accumulator, remaining multiplier bits};
// after W steps it holds the full 2W-bit product.
module alu_mul_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p,
    output logic           last
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]   mcand_reg;
    logic [2*W-1:0] prod_reg;
    logic [2*W-1:0] prod_next;
    logic [CW-1:0]  cnt_reg;
    logic           active_reg;
    logic [W:0]     sum;

    // One shift-add step: add the multiplicand when the current multiplier
    // bit is set, then shift the whole register right including the carry.
    always_comb begin
        sum       = {1'b0, prod_reg[2*W-1:W]} + {1'b0, ({W{prod_reg[0]}} & mcand_reg)};
        prod_next = {sum, prod_reg[W-1:1]};
    end

    // p already includes the step taken at the coming edge, so the
    // controller can capture the final product on the same edge as last.
    assign p    = prod_next;
    assign last = active_reg && (cnt_reg == CW'(W - 1));

    // Operand latch, step counter and product accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_reg  <= '0;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (load) begin
            mcand_reg  <= a;
            prod_reg   <= {{W{1'b0}}, b};
            cnt_reg    <= '0;
            active_reg <= 1'b1;
        end else if (active_reg) begin
            prod_reg <= prod_next;
            cnt_reg  <= cnt_reg + CW'(1);
            if (last) begin
                active_reg <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ops complete on the accepting edge, MUL runs
// through the shift-add multiplier and completes W edges later. Results and
// flags are written together on every completion; cf feeds back into ADC.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    state_t         state_reg;
    state_t         state_next;

    logic [W-1:0]   t_reg;
    logic           cf_reg;
    logic           zf_reg;
    logic           done_reg;

    logic           is_mul;
    logic           accept;
    logic           mul_load;
    logic           single_done;
    logic           busy;

    logic [W-1:0]   op_t;
    logic           op_cf;
    logic           op_zf;
    logic           op_valid;
    logic [W:0]     sum;

    logic [2*W-1:0] mul_p;
    logic           mul_last;

    assign is_mul = (bus.m == M_ARITH) && (bus.s == S_MUL);

    alu_mul_seq #(.W(W)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .load (mul_load),
        .a    (bus.a),
        .b    (bus.b),
        .p    (mul_p),
        .last (mul_last)
    );

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: only a MUL request leaves IDLE; the final step returns.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.start && is_mul) state_next = ST_MUL;
            ST_MUL:  if (mul_last)            state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Controller outputs: requests are only seen in IDLE, so start during
    // a multiply is dropped rather than queued.
    always_comb begin
        accept      = 1'b0;
        mul_load    = 1'b0;
        single_done = 1'b0;
        busy        = (state_reg == ST_MUL);
        if (state_reg == ST_IDLE && bus.start) begin
            accept      = 1'b1;
            mul_load    = is_mul;
            single_done = !is_mul;
        end
    end

    // Single-cycle datapath; unknown m/s pairs fall through as all-zero.
    always_comb begin
        sum      = '0;
        op_t     = '0;
        op_cf    = 1'b0;
        op_valid = 1'b0;
        if (bus.m == M_PASS) begin
            case (bus.s)
                S_PASS_A0, S_PASS_A1: op_t = bus.a;
                S_PASS_B:             op_t = bus.b;
                default:              op_t = '0;
            endcase
        end else begin
            op_valid = 1'b1;
            case (bus.s)
                S_ADD: begin
                    sum   = {1'b0, bus.a} + {1'b0, bus.b};
                    op_t  = sum[W-1:0];
                    op_cf = sum[W];
                end
                S_ADC: begin
                    sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, cf_reg};
                    op_t  = sum[W-1:0];
                    op_cf = sum[W];
                end
                S_SUB: begin
                    // b - a; the borrow lands in the top bit when a > b
                    sum   = {1'b0, bus.b} - {1'b0, bus.a};
                    op_t  = sum[W-1:0];
                    op_cf = sum[W];
                end
                S_AND:   op_t = bus.a & bus.b;
                S_OR:    op_t = bus.a | bus.b;
                S_XOR:   op_t = bus.a ^ bus.b;
                S_NOT:   op_t = ~bus.b;
                default: op_valid = 1'b0;
            endcase
        end
        op_zf = op_valid && (op_t == '0);
    end

    // Result and flag registers; every completion rewrites all three.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_reg    <= '0;
            cf_reg   <= 1'b0;
            zf_reg   <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (single_done) begin
                t_reg    <= op_t;
                cf_reg   <= op_cf;
                zf_reg   <= op_zf;
                done_reg <= 1'b1;
            end else if (mul_last) begin
                t_reg    <= mul_p[W-1:0];
                cf_reg   <= |mul_p[2*W-1:W];
                zf_reg   <= (mul_p[W-1:0] == '0);
                done_reg <= 1'b1;
            end
        end
    end

    assign bus.t    = t_reg;
    assign bus.cf   = cf_reg;
    assign bus.zf   = zf_reg;
    assign bus.done = done_reg;
    assign bus.busy = busy;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a W=8 and a W=16 instance share operand/mode lines and
// have separate start strobes. Table vectors, hand-written MUL sequences and
// random traffic checked against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8;
    logic        start16;
    logic        m;
    logic [3:0]  s;
    logic [15:0] a;
    logic [15:0] b;

    int checks = 0;
    int errors = 0;
    bit model_cf8;
    bit model_cf16;

    always #5 clk = ~clk;

    alu_seq_if #(.W(8))  bus8 ();
    alu_seq_if #(.W(16)) bus16 ();

    assign bus8.start  = start8;
    assign bus8.m      = m;
    assign bus8.s      = s;
    assign bus8.a      = a[7:0];
    assign bus8.b      = b[7:0];
    assign bus16.start = start16;
    assign bus16.m     = m;
    assign bus16.s     = s;
    assign bus16.a     = a;
    assign bus16.b     = b;

    alu_seq #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    alu_seq #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    typedef struct {
        bit         m;
        logic [3:0] s;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] t;
        bit         cf;
        bit         zf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model from the operation table, in plain integer arithmetic.
    function automatic void ref_op(input int wid, input bit mm, input logic [3:0] ss,
                                   input logic [15:0] aa_in, input logic [15:0] bb_in,
                                   input bit cin, output logic [15:0] rt,
                                   output bit rcf, output bit rzf);
        longint unsigned mask;
        longint unsigned aa;
        longint unsigned bb;
        longint unsigned full;
        longint unsigned res;
        bit valid;
        mask  = (64'd1 << wid) - 1;
        aa    = longint'(aa_in) & mask;
        bb    = longint'(bb_in) & mask;
        res   = 0;
        rcf   = 1'b0;
        valid = 1'b0;
        if (!mm) begin
            if (ss == 4'hC || ss == 4'h4) res = aa;
            else if (ss == 4'hA)          res = bb;
        end else begin
            valid = 1'b1;
            case (ss)
                4'h9: begin full = aa + bb;                 res = full & mask; rcf = (full >> wid) != 0; end
                4'h1: begin full = aa + bb + longint'(cin); res = full & mask; rcf = (full >> wid) != 0; end
                4'h6: begin res = (bb - aa) & mask; rcf = aa > bb; end
                4'hB: res = aa & bb;
                4'h2: res = aa | bb;
                4'h3: res = aa ^ bb;
                4'h5: res = (~bb) & mask;
                4'hE: begin full = aa * bb; res = full & mask; rcf = (full >> wid) != 0; end
                default: valid = 1'b0;
            endcase
        end
        rt  = res[15:0];
        rzf = valid && (res == 0);
    endfunction

    // Issue one request, wait (bounded) for done, return what the DUT shows.
    // Starts and ends on a falling edge, so consecutive calls are back-to-back.
    task automatic run_op(input int wid, input bit mm, input logic [3:0] ss,
                          input logic [15:0] aa, input logic [15:0] bb,
                          output logic [15:0] ot, output logic ocf, output logic ozf,
                          output int olat);
        logic dn;
        m = mm;
        s = ss;
        a = aa;
        b = bb;
        if (wid == 8) start8 = 1'b1;
        else          start16 = 1'b1;
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
        olat = 1;
        dn = (wid == 8) ? bus8.done : bus16.done;
        while (!dn && olat < 4 * wid + 8) begin
            @(negedge clk);
            olat++;
            dn = (wid == 8) ? bus8.done : bus16.done;
        end
        chk("done_seen", {31'd0, dn}, 32'd1);
        if (wid == 8) begin
            ot  = {8'h00, bus8.t};
            ocf = bus8.cf;
            ozf = bus8.zf;
        end else begin
            ot  = bus16.t;
            ocf = bus16.cf;
            ozf = bus16.zf;
        end
        $display("op w=%0d m=%0d s=%b a=%h b=%h -> t=%h cf=%0d zf=%0d lat=%0d",
                 wid, mm, ss, aa, bb, ot, ocf, ozf, olat);
    endtask

    initial begin
        vec_t        vecs[18];
        logic [3:0]  codes[12];
        logic [15:0] ot;
        logic        ocf;
        logic        ozf;
        int          lat;
        logic [15:0] et;
        bit          ecf;
        bit          ezf;

        vecs[0]  = '{1'b1, 4'b1001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 4'b0110, 8'h05, 8'h03, 8'hFE, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 4'b0110, 8'h03, 8'h05, 8'h02, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'b1001, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 4'b0001, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'b1100, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'b1111, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'b0100, 8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'b1010, 8'hA5, 8'h3C, 8'h3C, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'b1011, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 4'b0010, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 4'b0011, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 4'b0101, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 4'b1001, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 4'b0001, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 4'b0001, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 4'b1110, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 4'b0110, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1};

        codes = '{4'hC, 4'h4, 4'hA, 4'h9, 4'h1, 4'h6, 4'hB, 4'h2, 4'h3, 4'h5, 4'hE, 4'hF};

        rst = 1'b1; start8 = 1'b0; start16 = 1'b0; m = 1'b0; s = 4'h0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_t8",    {24'd0, bus8.t}, 32'd0);
        chk("rst_cf8",   {31'd0, bus8.cf}, 32'd0);
        chk("rst_zf8",   {31'd0, bus8.zf}, 32'd0);
        chk("rst_busy8", {31'd0, bus8.busy}, 32'd0);
        chk("rst_done8", {31'd0, bus8.done}, 32'd0);
        chk("rst_all16", {12'd0, bus16.t, bus16.cf, bus16.zf, bus16.busy, bus16.done}, 32'd0);
        rst = 1'b0;
        model_cf8  = 1'b0;
        model_cf16 = 1'b0;
        @(negedge clk);

        // Table of single-cycle ops on the 8-bit instance, each followed by
        // one idle cycle in which done must have dropped.
        for (int i = 0; i < 18; i++) begin
            run_op(8, vecs[i].m, vecs[i].s, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, ot, ocf, ozf, lat);
            chk($sformatf("vec%0d_res", i), {14'd0, ot, ocf, ozf},
                {14'd0, 8'h00, vecs[i].t, vecs[i].cf, vecs[i].zf});
            chk($sformatf("vec%0d_lat", i), lat, 32'd1);
            model_cf8 = vecs[i].cf;
            @(negedge clk);
            chk($sformatf("vec%0d_done_drop", i), {31'd0, bus8.done}, 32'd0);
        end

        // MUL 10*10: busy for 8 cycles, a start mid-op must be ignored,
        // operands wander freely, result lands after the 8th step.
        m = 1'b1; s = 4'hE; a = 16'h0010; b = 16'h0010; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("mul_busy%0d", j), {31'd0, bus8.busy}, 32'd1);
            chk($sformatf("mul_nodone%0d", j), {31'd0, bus8.done}, 32'd0);
            if (j == 3) begin
                start8 = 1'b1; s = 4'h9; a = 16'h0001; b = 16'h0001;
            end else begin
                start8 = 1'b0; s = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        chk("mul_end_busy", {31'd0, bus8.busy}, 32'd0);
        chk("mul_end_done", {31'd0, bus8.done}, 32'd1);
        chk("mul_res", {22'd0, bus8.t, bus8.cf, bus8.zf}, {22'd0, 8'h00, 1'b1, 1'b1});
        $display("op w=8 mul 10*10 -> t=%h cf=%0d zf=%0d", bus8.t, bus8.cf, bus8.zf);
        model_cf8 = 1'b1;
        @(negedge clk);
        chk("mul_ignored_start", {23'd0, bus8.done, bus8.t}, 32'h000);

        // Back-to-back: ADD issued in the cycle MUL's done is high.
        run_op(8, 1'b1, 4'hE, 16'h0003, 16'h0007, ot, ocf, ozf, lat);
        chk("b2b_mul_res", {14'd0, ot, ocf, ozf}, {14'd0, 16'h0015, 1'b0, 1'b0});
        chk("b2b_mul_lat", lat, 32'd9);
        run_op(8, 1'b1, 4'h9, 16'h0001, 16'h0002, ot, ocf, ozf, lat);
        chk("b2b_add_res", {14'd0, ot, ocf, ozf}, {14'd0, 16'h0003, 1'b0, 1'b0});
        chk("b2b_add_lat", lat, 32'd1);

        // Reset mid-MUL, with nonzero flags beforehand.
        run_op(8, 1'b1, 4'h9, 16'h00FF, 16'h0001, ot, ocf, ozf, lat);
        chk("pre_rst_res", {14'd0, ot, ocf, ozf}, {14'd0, 16'h0000, 1'b1, 1'b1});
        m = 1'b1; s = 4'hE; a = 16'h00FF; b = 16'h00FF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_t",    {24'd0, bus8.t}, 32'd0);
        chk("midrst_cf",   {31'd0, bus8.cf}, 32'd0);
        chk("midrst_zf",   {31'd0, bus8.zf}, 32'd0);
        chk("midrst_busy", {31'd0, bus8.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus8.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_cf8  = 1'b0;
        model_cf16 = 1'b0;
        @(negedge clk);
        chk("postrst_busy", {31'd0, bus8.busy}, 32'd0);
        run_op(8, 1'b1, 4'hE, 16'h0003, 16'h0005, ot, ocf, ozf, lat);
        chk("postrst_mul_res", {14'd0, ot, ocf, ozf}, {14'd0, 16'h000F, 1'b0, 1'b0});
        chk("postrst_mul_lat", lat, 32'd9);

        // 16-bit instance corner cases.
        run_op(16, 1'b1, 4'h9, 16'hFFFF, 16'h0001, ot, ocf, ozf, lat);
        chk("w16_add_res", {14'd0, ot, ocf, ozf}, {14'd0, 16'h0000, 1'b1, 1'b1});
        chk("w16_add_lat", lat, 32'd1);
        run_op(16, 1'b1, 4'h1, 16'hFFFF, 16'hFFFF, ot, ocf, ozf, lat);
        chk("w16_adc_res", {14'd0, ot, ocf, ozf}, {14'd0, 16'hFFFF, 1'b1, 1'b0});
        run_op(16, 1'b1, 4'hE, 16'h0100, 16'h0100, ot, ocf, ozf, lat);
        chk("w16_mul_res", {14'd0, ot, ocf, ozf}, {14'd0, 16'h0000, 1'b1, 1'b1});
        chk("w16_mul_lat", lat, 32'd17);
        model_cf16 = 1'b1;

        // Random traffic on both widths against the reference model.
        for (int n = 0; n < 200; n++) begin
            int          wid;
            bit          mm;
            logic [3:0]  ss;
            logic [15:0] aa;
            logic [15:0] bb;
            bit          cin;
            int          elat;
            wid = (n % 2 == 0) ? 8 : 16;
            mm  = ($urandom_range(0, 3) != 0);
            ss  = codes[$urandom_range(0, 11)];
            aa  = 16'($urandom);
            bb  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) aa = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) bb = 16'hFFFF;
            cin = (wid == 8) ? model_cf8 : model_cf16;
            ref_op(wid, mm, ss, aa, bb, cin, et, ecf, ezf);
            elat = (mm && ss == 4'hE) ? wid + 1 : 1;
            run_op(wid, mm, ss, aa, bb, ot, ocf, ozf, lat);
            chk($sformatf("rand%0d_res", n), {14'd0, ot, ocf, ozf}, {14'd0, et, ecf, ezf});
            chk($sformatf("rand%0d_lat", n), lat, elat);
            if (wid == 8) model_cf8 = ecf;
            else          model_cf16 = ecf;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
